// File: rtl/entry_timer_pkg.sv
// Shared encodings and defaults for the keypad entry / timer preset path.
package entry_timer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    LOAD    = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;

  localparam int DIGITS_DEF        = 4;
  localparam int TIMEOUT_TICKS_DEF = 3;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/timeout_counter.sv
// Saturating inactivity counter; expired looks one increment ahead so the
// FSM can leave ENTRY on the same edge that the limit is reached.
module timeout_counter #(
  parameter int CNT_W = 3,
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge clear) begin
    if (clear)                        r_count <= '0;
    else if (restart)                 r_count <= '0;
    else if (en && (r_count != '1))   r_count <= r_count + CNT_W'(1);
  end

  assign expired = (({1'b0, r_count} + {{CNT_W{1'b0}}, en}) == (CNT_W+1)'(LIMIT));
endmodule

// File: rtl/entry_timer_sequencer.sv
// Keypad entry controller: assembles a BCD preset, strobes it to the timer,
// and abandons entry after TIMEOUT_TICKS idle ticks.
module entry_timer_sequencer
  import entry_timer_pkg::*;
#(
  parameter int DIGITS        = DIGITS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int CNT_W         = 3
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                tick,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                busy,
  output logic [4*DIGITS-1:0] value,
  output logic                load,
  output logic                timeout,
  output logic [1:0]          state_o
);
  localparam int NW = $clog2(DIGITS + 1);

  state_t              r_state, w_nstate;
  logic [4*DIGITS-1:0] r_value, w_nvalue;
  logic [NW-1:0]       r_ndig, w_nndig;
  logic                r_load, r_timeout;
  logic                w_digit, w_room, w_restart, w_en, w_expired;

  assign w_digit   = key_valid && is_digit(key_code);
  assign w_room    = r_ndig < NW'(DIGITS);
  assign w_restart = w_digit && ((r_state == IDLE) || ((r_state == ENTRY) && w_room));
  // Any key in the same cycle swallows the tick, even one with no effect.
  assign w_en      = (r_state == ENTRY) && tick && !key_valid;

  timeout_counter #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_TICKS)) u_tmo (
    .clk     (clk),
    .clear   (clear),
    .restart (w_restart),
    .en      (w_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= IDLE;
      r_value   <= '0;
      r_ndig    <= '0;
      r_load    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_value   <= w_nvalue;
      r_ndig    <= w_nndig;
      r_load    <= (r_state == LOAD);
      r_timeout <= (w_nstate == EXPIRED);
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nvalue = r_value;
    w_nndig  = r_ndig;
    unique case (r_state)
      IDLE: if (w_digit) begin
        w_nvalue = {{(4*DIGITS-4){1'b0}}, key_code};
        w_nndig  = NW'(1);
        w_nstate = ENTRY;
      end
      ENTRY: begin
        if (key_valid) begin
          if (w_digit) begin
            if (w_room) begin
              w_nvalue = {r_value[4*DIGITS-5:0], key_code};
              w_nndig  = r_ndig + NW'(1);
            end
          end else if ((key_code == KEY_ENTER) && !busy) begin
            w_nstate = LOAD;
          end else if (key_code == KEY_CANCEL) begin
            w_nvalue = '0;
            w_nndig  = '0;
            w_nstate = IDLE;
          end
        end else if (w_en && w_expired) begin
          w_nvalue = '0;
          w_nndig  = '0;
          w_nstate = EXPIRED;
        end
      end
      LOAD: begin
        w_nndig  = '0;
        w_nstate = IDLE;
      end
      EXPIRED: if (key_valid) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  assign value   = r_value;
  assign load    = r_load;
  assign timeout = r_timeout;
  assign state_o = r_state;
endmodule

// File: tb/tb_entry_timer_sequencer.sv
// Directed bench: a vector table for the cycle-by-cycle function plus
// hand sequences for asynchronous clear.
module tb_entry_timer_sequencer;
  logic        clk = 1'b0;
  logic        clear, tick, key_valid, busy;
  logic [3:0]  key_code;
  logic [15:0] value;
  logic        load, timeout;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  entry_timer_sequencer dut (
    .clk       (clk),
    .clear     (clear),
    .tick      (tick),
    .key_valid (key_valid),
    .key_code  (key_code),
    .busy      (busy),
    .value     (value),
    .load      (load),
    .timeout   (timeout),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        tk;
    logic        bs;
    logic [15:0] ev;
    logic [1:0]  es;
    logic        el;
    logic        et;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic kv, input logic [3:0] kc, input logic tk, input logic bs,
                     input logic [15:0] ev, input logic [1:0] es, input logic el, input logic et);
    vec_t v;
    v.kv = kv; v.kc = kc; v.tk = tk; v.bs = bs;
    v.ev = ev; v.es = es; v.el = el; v.et = et;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kc, input logic tk, input logic bs);
    key_valid = kv; key_code = kc; tick = tk; busy = bs;
    @(posedge clk);
    #1;
    key_valid = 1'b0; tick = 1'b0; busy = 1'b0; key_code = 4'h0;
  endtask

  initial begin
    clear = 1'b1; tick = 1'b0; key_valid = 1'b0; busy = 1'b0; key_code = 4'h0;

    // 1,2,3,0 then ENTER; load strobe one cycle later
    add(1,4'h1,0,0,16'h0001,1,0,0); add(1,4'h2,0,0,16'h0012,1,0,0);
    add(1,4'h3,0,0,16'h0123,1,0,0); add(1,4'h0,0,0,16'h1230,1,0,0);
    add(1,4'hA,0,0,16'h1230,2,0,0); add(0,4'h0,0,0,16'h1230,0,1,0);
    add(0,4'h0,0,0,16'h1230,0,0,0);
    // fifth digit ignored and does not restart the counter
    add(1,4'h1,0,0,16'h0001,1,0,0); add(1,4'h2,0,0,16'h0012,1,0,0);
    add(1,4'h3,0,0,16'h0123,1,0,0); add(1,4'h0,0,0,16'h1230,1,0,0);
    add(1,4'h9,0,0,16'h1230,1,0,0); add(0,4'h0,1,0,16'h1230,1,0,0);
    add(0,4'h0,1,0,16'h1230,1,0,0); add(0,4'h0,1,0,16'h0000,3,0,1);
    add(0,4'h0,1,0,16'h0000,3,0,1); add(1,4'h7,0,0,16'h0000,0,0,0);
    // plain expiry, exit key consumed
    add(1,4'h5,0,0,16'h0005,1,0,0); add(0,4'h0,1,0,16'h0005,1,0,0);
    add(0,4'h0,1,0,16'h0005,1,0,0); add(0,4'h0,1,0,16'h0000,3,0,1);
    add(1,4'h7,0,0,16'h0000,0,0,0);
    // key + tick together: key wins, counter restarts
    add(1,4'h5,0,0,16'h0005,1,0,0); add(0,4'h0,1,0,16'h0005,1,0,0);
    add(0,4'h0,1,0,16'h0005,1,0,0); add(1,4'h7,1,0,16'h0057,1,0,0);
    add(0,4'h0,1,0,16'h0057,1,0,0); add(0,4'h0,1,0,16'h0057,1,0,0);
    add(0,4'h0,1,0,16'h0000,3,0,1); add(1,4'hC,0,0,16'h0000,0,0,0);
    // busy ENTER, CANCEL, ENTER in IDLE
    add(1,4'h4,0,0,16'h0004,1,0,0); add(1,4'hA,0,1,16'h0004,1,0,0);
    add(0,4'h0,0,0,16'h0004,1,0,0); add(1,4'hB,0,0,16'h0000,0,0,0);
    add(1,4'hA,0,0,16'h0000,0,0,0); add(0,4'h0,0,0,16'h0000,0,0,0);
    // ignored code + tick: tick discarded, counter holds
    add(1,4'h6,0,0,16'h0006,1,0,0); add(0,4'h0,1,0,16'h0006,1,0,0);
    add(0,4'h0,1,0,16'h0006,1,0,0); add(1,4'hC,1,0,16'h0006,1,0,0);
    add(0,4'h0,1,0,16'h0000,3,0,1); add(1,4'h6,0,0,16'h0000,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset value",   32'(value),   32'h0);
    chk("reset state",   32'(state_o), 32'h0);
    chk("reset load",    32'(load),    32'h0);
    chk("reset timeout", 32'(timeout), 32'h0);
    clear = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].kv, vq[i].kc, vq[i].tk, vq[i].bs);
      chk($sformatf("v%0d value", i),   32'(value),   32'(vq[i].ev));
      chk($sformatf("v%0d state", i),   32'(state_o), 32'(vq[i].es));
      chk($sformatf("v%0d load", i),    32'(load),    32'(vq[i].el));
      chk($sformatf("v%0d timeout", i), 32'(timeout), 32'(vq[i].et));
    end

    // clear while in LOAD state: no strobe ever appears
    step(1, 4'h1, 0, 0); step(1, 4'h2, 0, 0); step(1, 4'hA, 0, 0);
    chk("h1 pre state", 32'(state_o), 32'h2);
    clear = 1'b1; #1;
    chk("h1 clr state", 32'(state_o), 32'h0);
    chk("h1 clr value", 32'(value),   32'h0);
    chk("h1 clr load",  32'(load),    32'h0);
    #1 clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0, 4'h0, 0, 0);
      chk($sformatf("h1 no replay %0d", k), 32'(load), 32'h0);
    end

    // clear during the load-strobe cycle
    step(1, 4'h3, 0, 0); step(1, 4'hA, 0, 0); step(0, 4'h0, 0, 0);
    chk("h2 load high", 32'(load),  32'h1);
    chk("h2 value",     32'(value), 32'h0003);
    clear = 1'b1; #1;
    chk("h2 clr load",  32'(load),    32'h0);
    chk("h2 clr value", 32'(value),   32'h0);
    chk("h2 clr state", 32'(state_o), 32'h0);
    #1 clear = 1'b0;
    step(0, 4'h0, 0, 0);
    chk("h2 no replay", 32'(load), 32'h0);

    // clear while EXPIRED
    step(1, 4'h5, 0, 0); step(0, 4'h0, 1, 0); step(0, 4'h0, 1, 0); step(0, 4'h0, 1, 0);
    chk("h3 timeout", 32'(timeout), 32'h1);
    clear = 1'b1; #1;
    chk("h3 clr timeout", 32'(timeout), 32'h0);
    chk("h3 clr state",   32'(state_o), 32'h0);
    #1 clear = 1'b0;

    // clear mid-ENTRY
    step(1, 4'h8, 0, 0); step(1, 4'h1, 0, 0);
    chk("h4 value", 32'(value), 32'h0081);
    clear = 1'b1; #1;
    chk("h4 clr value", 32'(value),   32'h0);
    chk("h4 clr state", 32'(state_o), 32'h0);
    #1 clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
